// File: rtl/scr1_memif_pkg.sv
// Core/target memory interface types shared across the dmem path.
//   type_scr1_mem_cmd_e   : read / write command
//   type_scr1_mem_width_e : access width
//   type_scr1_mem_resp_e  : target response (not ready / ok / error)
package scr1_memif_pkg;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

endpackage : scr1_memif_pkg

// File: rtl/scr1_router_pkg.sv
// Router-local types and helpers.
//   type_scr1_router_fsm_e : router transaction state
//   port_match()           : address window test, (addr & mask) == base
package scr1_router_pkg;

  // Widest address the window helper accepts; callers zero-extend.
  localparam int unsigned SCR1_ROUTER_AW_MAX = 64;

  typedef enum logic [1:0] {
    SCR1_ROUTER_ADDR  = 2'b00,
    SCR1_ROUTER_DATA  = 2'b01,
    SCR1_ROUTER_DRAIN = 2'b10
  } type_scr1_router_fsm_e;

  function automatic logic port_match(
    input logic [SCR1_ROUTER_AW_MAX-1:0] addr,
    input logic [SCR1_ROUTER_AW_MAX-1:0] base,
    input logic [SCR1_ROUTER_AW_MAX-1:0] mask
  );
    return ((addr & mask) == base);
  endfunction

endpackage : scr1_router_pkg

// File: rtl/scr1_router_addr_dec.sv
// Priority address decoder for the dmem router.
//   addr    : request address
//   hit     : some window matched, or a default port exists
//   dec_sel : lowest-index matching port; last port when nothing matched
// With DFLT_EN the last port is the catch-all and is never decoded itself.
module scr1_router_addr_dec
  import scr1_router_pkg::*;
#(
  parameter int unsigned                   PORT_NUM  = 3,
  parameter int unsigned                   AWIDTH    = 32,
  parameter logic [PORT_NUM*AWIDTH-1:0]    PORT_BASE = '0,
  parameter logic [PORT_NUM*AWIDTH-1:0]    PORT_MASK = '0,
  parameter bit                            DFLT_EN   = 1'b1,
  parameter int unsigned                   SW        = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1
) (
  input  logic [AWIDTH-1:0] addr,
  output logic              hit,
  output logic [SW-1:0]     dec_sel
);

  logic found;

  always_comb begin
    found   = 1'b0;
    dec_sel = SW'(PORT_NUM - 1);
    for (int unsigned i = 0; i < PORT_NUM; i++) begin
      if (!found && !(DFLT_EN && (i == PORT_NUM - 1)) &&
          port_match(SCR1_ROUTER_AW_MAX'(addr),
                     SCR1_ROUTER_AW_MAX'(PORT_BASE[i*AWIDTH +: AWIDTH]),
                     SCR1_ROUTER_AW_MAX'(PORT_MASK[i*AWIDTH +: AWIDTH]))) begin
        found   = 1'b1;
        dec_sel = SW'(i);
      end
    end
    hit = found || DFLT_EN;
  end

endmodule : scr1_router_addr_dec

// File: rtl/scr1_dmem_router_mp.sv
// Multi-port data-memory router: core dmem interface -> PORT_NUM targets.
//   clk, rst            : clock, synchronous active-high reset
//   core_*              : core request/response side
//   port_req_o          : one-hot (or zero) per-target request
//   port_cmd/width/addr/wdata_o : broadcast copies of the core request
//   port_req_ack_i, port_rdata_i, port_resp_i : per-target handshake/response
// One transaction outstanding. Unmapped addresses either fall to the last
// port (DFLT_EN) or get an error response. A non-zero TIMEOUT_CYC bounds the
// response wait; a timed-out transaction is drained and its late response
// dropped.
module scr1_dmem_router_mp
  import scr1_memif_pkg::*;
  import scr1_router_pkg::*;
#(
  parameter int unsigned                PORT_NUM    = 3,
  parameter int unsigned                AWIDTH      = 32,
  parameter int unsigned                DWIDTH      = 32,
  // Listed high port first: port 2 = default (0/0), port 1 = timer, port 0 = TCM.
  parameter logic [PORT_NUM*AWIDTH-1:0] PORT_BASE   = {32'h0000_0000, 32'hF004_0000, 32'hF000_0000},
  parameter logic [PORT_NUM*AWIDTH-1:0] PORT_MASK   = {32'h0000_0000, 32'hFFFF_FFE0, 32'hFFFF_0000},
  parameter bit                         DFLT_EN     = 1'b1,
  parameter int unsigned                TIMEOUT_CYC = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       core_req_ack_o,
  input  logic                       core_req_i,
  input  type_scr1_mem_cmd_e         core_cmd_i,
  input  type_scr1_mem_width_e       core_width_i,
  input  logic [AWIDTH-1:0]          core_addr_i,
  input  logic [DWIDTH-1:0]          core_wdata_i,
  output logic [DWIDTH-1:0]          core_rdata_o,
  output type_scr1_mem_resp_e        core_resp_o,
  input  logic [PORT_NUM-1:0]        port_req_ack_i,
  output logic [PORT_NUM-1:0]        port_req_o,
  output type_scr1_mem_cmd_e         port_cmd_o,
  output type_scr1_mem_width_e       port_width_o,
  output logic [AWIDTH-1:0]          port_addr_o,
  output logic [DWIDTH-1:0]          port_wdata_o,
  input  logic [PORT_NUM*DWIDTH-1:0] port_rdata_i,
  input  logic [PORT_NUM*2-1:0]      port_resp_i
);

  localparam int unsigned   SW       = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
  localparam int unsigned   TW       = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = (TIMEOUT_CYC > 0) ? TW'(TIMEOUT_CYC - 1) : '0;

  type_scr1_router_fsm_e state;
  logic [SW-1:0]         sel;
  logic                  err_flag;
  logic [TW-1:0]         tmo_cnt;

  logic                  hit;
  logic [SW-1:0]         dec_sel;
  type_scr1_mem_resp_e   resp_arr  [PORT_NUM];
  logic [DWIDTH-1:0]     rdata_arr [PORT_NUM];
  type_scr1_mem_resp_e   sel_resp;
  logic [DWIDTH-1:0]     sel_rdata;
  logic                  resp_rdy;
  logic                  tmo_hit;
  logic                  issue;
  logic                  hs;

  scr1_router_addr_dec #(
    .PORT_NUM  (PORT_NUM),
    .AWIDTH    (AWIDTH),
    .PORT_BASE (PORT_BASE),
    .PORT_MASK (PORT_MASK),
    .DFLT_EN   (DFLT_EN),
    .SW        (SW)
  ) u_dec (
    .addr    (core_addr_i),
    .hit     (hit),
    .dec_sel (dec_sel)
  );

  for (genvar g = 0; g < PORT_NUM; g++) begin : g_unpack
    assign resp_arr[g]  = type_scr1_mem_resp_e'(port_resp_i[g*2 +: 2]);
    assign rdata_arr[g] = port_rdata_i[g*DWIDTH +: DWIDTH];
  end

  assign port_cmd_o   = core_cmd_i;
  assign port_width_o = core_width_i;
  assign port_addr_o  = core_addr_i;
  assign port_wdata_o = core_wdata_i;

  always_comb begin
    sel_resp  = resp_arr[sel];
    sel_rdata = rdata_arr[sel];
    resp_rdy  = err_flag || (sel_resp != SCR1_MEM_RESP_NOTRDY);
    tmo_hit   = (TIMEOUT_CYC > 0) && (state == SCR1_ROUTER_DATA) &&
                !resp_rdy && (tmo_cnt == TMO_LAST);
    // Issuing while the current response completes gives zero-bubble
    // back-to-back; a timeout cycle is not a completion and does not issue.
    issue     = !rst && ((state == SCR1_ROUTER_ADDR) ||
                         ((state == SCR1_ROUTER_DATA) && resp_rdy));

    port_req_o     = '0;
    core_req_ack_o = 1'b0;
    if (issue) begin
      if (hit) begin
        port_req_o[dec_sel] = core_req_i;
        core_req_ack_o      = port_req_ack_i[dec_sel];
      end else begin
        core_req_ack_o = core_req_i;
      end
    end
    hs = core_req_i && core_req_ack_o;

    core_resp_o  = SCR1_MEM_RESP_NOTRDY;
    core_rdata_o = '0;
    if (!rst && (state == SCR1_ROUTER_DATA)) begin
      if (err_flag || tmo_hit) begin
        core_resp_o = SCR1_MEM_RESP_RDY_ER;
      end else begin
        core_resp_o  = sel_resp;
        core_rdata_o = sel_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SCR1_ROUTER_ADDR;
      sel      <= '0;
      err_flag <= 1'b0;
      tmo_cnt  <= '0;
    end else begin
      unique case (state)
        SCR1_ROUTER_ADDR: begin
          if (hs) begin
            sel      <= dec_sel;
            err_flag <= !hit;
            tmo_cnt  <= '0;
            state    <= SCR1_ROUTER_DATA;
          end
        end
        SCR1_ROUTER_DATA: begin
          if (hs) begin
            sel      <= dec_sel;
            err_flag <= !hit;
            tmo_cnt  <= '0;
          end else if (resp_rdy) begin
            state <= SCR1_ROUTER_ADDR;
          end else if (tmo_hit) begin
            state <= SCR1_ROUTER_DRAIN;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        SCR1_ROUTER_DRAIN: begin
          // Wait out the abandoned target; its response never reaches the core.
          if (sel_resp != SCR1_MEM_RESP_NOTRDY) begin
            state <= SCR1_ROUTER_ADDR;
          end
        end
        default: state <= SCR1_ROUTER_ADDR;
      endcase
    end
  end

endmodule : scr1_dmem_router_mp

// File: tb/tb_scr1_dmem_router_mp.sv
// Directed bench: instance A (default map, default port, 4-cycle timeout) and
// instance B (overlapping windows, no default port, no timeout). Request and
// target inputs are shared; the instance not under test is held in reset.
// Observed vector per cycle: {ack, port_req[2:0], resp[1:0], rdata[31:0]}.
module tb_scr1_dmem_router_mp;
  import scr1_memif_pkg::*;

  localparam logic [1:0] NR = 2'd0;
  localparam logic [1:0] OK = 2'd1;
  localparam logic [1:0] ER = 2'd2;

  logic                 clk = 1'b0;
  logic                 rst_a, rst_b;
  logic                 core_req;
  type_scr1_mem_cmd_e   core_cmd;
  type_scr1_mem_width_e core_width;
  logic [31:0]          core_addr, core_wdata;
  logic [2:0]           port_req_ack;
  logic [95:0]          port_rdata;
  logic [5:0]           port_resp;

  logic                 a_ack, b_ack;
  logic [31:0]          a_rdata, b_rdata, a_addr, b_addr, a_wdata, b_wdata;
  type_scr1_mem_resp_e  a_resp, b_resp;
  logic [2:0]           a_req, b_req;
  type_scr1_mem_cmd_e   a_cmd, b_cmd;
  type_scr1_mem_width_e a_width, b_width;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [37:0] exp;
  logic [66:0] bexp;

  always #5 clk = ~clk;

  scr1_dmem_router_mp #(
    .PORT_NUM    (3),
    .AWIDTH      (32),
    .DWIDTH      (32),
    .PORT_BASE   ({32'h0000_0000, 32'hF004_0000, 32'hF000_0000}),
    .PORT_MASK   ({32'h0000_0000, 32'hFFFF_FFE0, 32'hFFFF_0000}),
    .DFLT_EN     (1'b1),
    .TIMEOUT_CYC (4)
  ) u_dut_a (
    .clk (clk), .rst (rst_a),
    .core_req_ack_o (a_ack), .core_req_i (core_req), .core_cmd_i (core_cmd),
    .core_width_i (core_width), .core_addr_i (core_addr), .core_wdata_i (core_wdata),
    .core_rdata_o (a_rdata), .core_resp_o (a_resp),
    .port_req_ack_i (port_req_ack), .port_req_o (a_req), .port_cmd_o (a_cmd),
    .port_width_o (a_width), .port_addr_o (a_addr), .port_wdata_o (a_wdata),
    .port_rdata_i (port_rdata), .port_resp_i (port_resp)
  );

  scr1_dmem_router_mp #(
    .PORT_NUM    (3),
    .AWIDTH      (32),
    .DWIDTH      (32),
    .PORT_BASE   ({32'hF004_0000, 32'hF000_0000, 32'hF000_0000}),
    .PORT_MASK   ({32'hFFFF_FFE0, 32'hFFF0_0000, 32'hFFFF_0000}),
    .DFLT_EN     (1'b0),
    .TIMEOUT_CYC (0)
  ) u_dut_b (
    .clk (clk), .rst (rst_b),
    .core_req_ack_o (b_ack), .core_req_i (core_req), .core_cmd_i (core_cmd),
    .core_width_i (core_width), .core_addr_i (core_addr), .core_wdata_i (core_wdata),
    .core_rdata_o (b_rdata), .core_resp_o (b_resp),
    .port_req_ack_i (port_req_ack), .port_req_o (b_req), .port_cmd_o (b_cmd),
    .port_width_o (b_width), .port_addr_o (b_addr), .port_wdata_o (b_wdata),
    .port_rdata_i (port_rdata), .port_resp_i (port_resp)
  );

  function automatic logic [37:0] obs_a();
    return {a_ack, a_req, a_resp, a_rdata};
  endfunction

  function automatic logic [37:0] obs_b();
    return {b_ack, b_req, b_resp, b_rdata};
  endfunction

  task automatic set_port(input int p, input logic [1:0] r, input logic [31:0] d);
    port_resp[p*2 +: 2]   = r;
    port_rdata[p*32 +: 32] = d;
  endtask

  task automatic core_drive(input logic req, input type_scr1_mem_cmd_e cmd,
                            input logic [31:0] addr, input logic [2:0] ack);
    core_req     = req;
    core_cmd     = cmd;
    core_addr    = addr;
    port_req_ack = ack;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    core_drive(1'b1, SCR1_MEM_CMD_RD, 32'hF000_0010, 3'b111);
    set_port(0, OK, 32'hFFFF_FFFF);
    exp = '0;
    @(negedge clk);
    n_cmp++;
    if (obs_a() !== exp) begin n_fail++; $display("FAIL reset_a: got %h exp %h", obs_a(), exp); end
    n_cmp++;
    if (obs_b() !== exp) begin n_fail++; $display("FAIL reset_b: got %h exp %h", obs_b(), exp); end
    next_cycle();
    rst_a = 1'b0;
    core_drive(1'b0, SCR1_MEM_CMD_RD, 32'h0, 3'b000);
    port_resp = '0; port_rdata = '0;
    @(negedge clk);
    n_cmp++;
    if (obs_a() !== exp) begin n_fail++; $display("FAIL post_reset_idle: got %h exp %h", obs_a(), exp); end
    next_cycle();
  endtask

  task automatic test_read_port0();
    core_drive(1'b1, SCR1_MEM_CMD_RD, 32'hF000_0010, 3'b001);
    exp = {1'b1, 3'b001, NR, 32'h0};
    @(negedge clk);
    n_cmp++;
    if (obs_a() !== exp) begin n_fail++; $display("FAIL rd0_issue: got %h exp %h", obs_a(), exp); end
    next_cycle();
    core_drive(1'b0, SCR1_MEM_CMD_RD, 32'h0, 3'b000);
    for (int w = 0; w < 2; w++) begin
      exp = {1'b0, 3'b000, NR, 32'h0};
      @(negedge clk);
      n_cmp++;
      if (obs_a() !== exp) begin n_fail++; $display("FAIL rd0_wait%0d: got %h exp %h", w, obs_a(), exp); end
      next_cycle();
    end
    set_port(0, OK, 32'h1234_5678);
    exp = {1'b0, 3'b000, OK, 32'h1234_5678};
    @(negedge clk);
    n_cmp++;
    if (obs_a() !== exp) begin n_fail++; $display("FAIL rd0_resp: got %h exp %h", obs_a(), exp); end
    next_cycle();
    set_port(0, NR, 32'h1234_5678);
    exp = '0;
    @(negedge clk);
    n_cmp++;
    if (obs_a() !== exp) begin n_fail++; $display("FAIL rd0_idle: got %h exp %h", obs_a(), exp); end
    next_cycle();
    set_port(0, NR, 32'h0);
  endtask

  task automatic test_back_to_back();
    core_drive(1'b1, SCR1_MEM_CMD_WR, 32'hF004_0004, 3'b010);
    core_width = SCR1_MEM_WIDTH_HWORD;
    core_wdata = 32'h0BAD_F00D;
    exp  = {1'b1, 3'b010, NR, 32'h0};
    bexp = {1'b1, 2'b01, 32'hF004_0004, 32'h0BAD_F00D};
    @(negedge clk);
    n_cmp++;
    if (obs_a() !== exp) begin n_fail++; $display("FAIL b2b_wr_issue: got %h exp %h", obs_a(), exp); end
    n_cmp++;
    if ({a_cmd, a_width, a_addr, a_wdata} !== bexp) begin
      n_fail++; $display("FAIL b2b_broadcast: got %h exp %h", {a_cmd, a_width, a_addr, a_wdata}, bexp);
    end
    next_cycle();
    // Next request waits behind the outstanding write.
    core_drive(1'b1, SCR1_MEM_CMD_RD, 32'h2000_0000, 3'b100);
    core_width = SCR1_MEM_WIDTH_WORD;
    exp = {1'b0, 3'b000, NR, 32'h0};
    @(negedge clk);
    n_cmp++;
    if (obs_a() !== exp) begin n_fail++; $display("FAIL b2b_held: got %h exp %h", obs_a(), exp); end
    next_cycle();
    set_port(1, OK, 32'hDEAD_BEEF);
    exp = {1'b1, 3'b100, OK, 32'hDEAD_BEEF};
    @(negedge clk);
    n_cmp++;
    if (obs_a() !== exp) begin n_fail++; $display("FAIL b2b_overlap: got %h exp %h", obs_a(), exp); end
    next_cycle();
    core_drive(1'b0, SCR1_MEM_CMD_RD, 32'h0, 3'b000);
    set_port(1, NR, 32'h0);
    set_port(2, OK, 32'hCAFE_0002);
    exp = {1'b0, 3'b000, OK, 32'hCAFE_0002};
    @(negedge clk);
    n_cmp++;
    if (obs_a() !== exp) begin n_fail++; $display("FAIL b2b_rd_resp: got %h exp %h", obs_a(), exp); end
    next_cycle();
    set_port(2, NR, 32'h0);
    exp = '0;
    @(negedge clk);
    n_cmp++;
    if (obs_a() !== exp) begin n_fail++; $display("FAIL b2b_idle: got %h exp %h", obs_a(), exp); end
    next_cycle();
  endtask

  task automatic test_timeout();
    core_drive(1'b1, SCR1_MEM_CMD_RD, 32'h2000_0000, 3'b100);
    exp = {1'b1, 3'b100, NR, 32'h0};
    @(negedge clk);
    n_cmp++;
    if (obs_a() !== exp) begin n_fail++; $display("FAIL tmo_issue: got %h exp %h", obs_a(), exp); end
    next_cycle();
    core_drive(1'b0, SCR1_MEM_CMD_RD, 32'h0, 3'b000);
    for (int w = 0; w < 3; w++) begin
      exp = '0;
      @(negedge clk);
      n_cmp++;
      if (obs_a() !== exp) begin n_fail++; $display("FAIL tmo_wait%0d: got %h exp %h", w, obs_a(), exp); end
      next_cycle();
    end
    exp = {1'b0, 3'b000, ER, 32'h0};
    @(negedge clk);
    n_cmp++;
    if (obs_a() !== exp) begin n_fail++; $display("FAIL tmo_err: got %h exp %h", obs_a(), exp); end
    next_cycle();
    // Draining: new requests are refused, late response is swallowed.
    core_drive(1'b1, SCR1_MEM_CMD_RD, 32'hF000_0010, 3'b111);
    for (int w = 0; w < 3; w++) begin
      if (w == 2) set_port(2, OK, 32'hBAD0_0BAD);
      exp = '0;
      @(negedge clk);
      n_cmp++;
      if (obs_a() !== exp) begin n_fail++; $display("FAIL tmo_drain%0d: got %h exp %h", w, obs_a(), exp); end
      next_cycle();
    end
    set_port(2, NR, 32'h0);
    port_req_ack = 3'b001;
    exp = {1'b1, 3'b001, NR, 32'h0};
    @(negedge clk);
    n_cmp++;
    if (obs_a() !== exp) begin n_fail++; $display("FAIL tmo_reissue: got %h exp %h", obs_a(), exp); end
    next_cycle();
    core_drive(1'b0, SCR1_MEM_CMD_RD, 32'h0, 3'b000);
    set_port(0, OK, 32'h0000_0011);
    exp = {1'b0, 3'b000, OK, 32'h0000_0011};
    @(negedge clk);
    n_cmp++;
    if (obs_a() !== exp) begin n_fail++; $display("FAIL tmo_recover: got %h exp %h", obs_a(), exp); end
    next_cycle();
    set_port(0, NR, 32'h0);
  endtask

  task automatic test_reset_mid();
    core_drive(1'b1, SCR1_MEM_CMD_RD, 32'hF000_0000, 3'b001);
    next_cycle();
    core_drive(1'b0, SCR1_MEM_CMD_RD, 32'h0, 3'b000);
    next_cycle();
    rst_a = 1'b1;
    set_port(0, OK, 32'h7777_7777);
    exp = '0;
    @(negedge clk);
    n_cmp++;
    if (obs_a() !== exp) begin n_fail++; $display("FAIL rstmid_during: got %h exp %h", obs_a(), exp); end
    next_cycle();
    rst_a = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs_a() !== exp) begin n_fail++; $display("FAIL rstmid_after: got %h exp %h", obs_a(), exp); end
    next_cycle();
    set_port(0, NR, 32'h0);
    core_drive(1'b1, SCR1_MEM_CMD_RD, 32'hF004_0010, 3'b010);
    exp = {1'b1, 3'b010, NR, 32'h0};
    @(negedge clk);
    n_cmp++;
    if (obs_a() !== exp) begin n_fail++; $display("FAIL rstmid_issue: got %h exp %h", obs_a(), exp); end
    next_cycle();
    core_drive(1'b0, SCR1_MEM_CMD_RD, 32'h0, 3'b000);
    set_port(1, OK, 32'h0000_55AA);
    exp = {1'b0, 3'b000, OK, 32'h0000_55AA};
    @(negedge clk);
    n_cmp++;
    if (obs_a() !== exp) begin n_fail++; $display("FAIL rstmid_resp: got %h exp %h", obs_a(), exp); end
    next_cycle();
    set_port(1, NR, 32'h0);
  endtask

  task automatic test_decode_error();
    rst_a = 1'b1;
    rst_b = 1'b0;
    core_drive(1'b1, SCR1_MEM_CMD_RD, 32'h2000_0000, 3'b111);
    exp = {1'b1, 3'b000, NR, 32'h0};
    @(negedge clk);
    n_cmp++;
    if (obs_b() !== exp) begin n_fail++; $display("FAIL derr_ack: got %h exp %h", obs_b(), exp); end
    next_cycle();
    core_drive(1'b0, SCR1_MEM_CMD_RD, 32'h0, 3'b000);
    set_port(0, OK, 32'hAAAA_0000);
    set_port(2, OK, 32'hAAAA_0002);
    exp = {1'b0, 3'b000, ER, 32'h0};
    @(negedge clk);
    n_cmp++;
    if (obs_b() !== exp) begin n_fail++; $display("FAIL derr_resp: got %h exp %h", obs_b(), exp); end
    next_cycle();
    exp = '0;
    @(negedge clk);
    n_cmp++;
    if (obs_b() !== exp) begin n_fail++; $display("FAIL derr_idle: got %h exp %h", obs_b(), exp); end
    next_cycle();
    port_resp = '0; port_rdata = '0;
  endtask

  task automatic test_overlap();
    core_drive(1'b1, SCR1_MEM_CMD_RD, 32'hF000_0000, 3'b111);
    exp = {1'b1, 3'b001, NR, 32'h0};
    @(negedge clk);
    n_cmp++;
    if (obs_b() !== exp) begin n_fail++; $display("FAIL ovl_p0_issue: got %h exp %h", obs_b(), exp); end
    next_cycle();
    // Port 1 answers too but is not selected; only port 0 data may appear.
    set_port(0, OK, 32'h0000_00A0);
    set_port(1, OK, 32'h0000_00A1);
    core_drive(1'b1, SCR1_MEM_CMD_RD, 32'hF001_0000, 3'b111);
    exp = {1'b1, 3'b010, OK, 32'h0000_00A0};
    @(negedge clk);
    n_cmp++;
    if (obs_b() !== exp) begin n_fail++; $display("FAIL ovl_p1_b2b: got %h exp %h", obs_b(), exp); end
    next_cycle();
    core_drive(1'b0, SCR1_MEM_CMD_RD, 32'h0, 3'b000);
    exp = {1'b0, 3'b000, OK, 32'h0000_00A1};
    @(negedge clk);
    n_cmp++;
    if (obs_b() !== exp) begin n_fail++; $display("FAIL ovl_p1_resp: got %h exp %h", obs_b(), exp); end
    next_cycle();
    port_resp = '0; port_rdata = '0;
  endtask

  initial begin
    rst_a        = 1'b1;
    rst_b        = 1'b1;
    core_req     = 1'b0;
    core_cmd     = SCR1_MEM_CMD_RD;
    core_width   = SCR1_MEM_WIDTH_WORD;
    core_addr    = '0;
    core_wdata   = '0;
    port_req_ack = '0;
    port_rdata   = '0;
    port_resp    = '0;
    next_cycle();
    test_reset();
    test_read_port0();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_decode_error();
    test_overlap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_scr1_dmem_router_mp

// File: doc/scr1_dmem_router_mp.md
Name: scr1_dmem_router_mp

Overview:
- Parametrised multi-port data-memory router between the core dmem interface and PORT_NUM targets (TCM, memory-mapped timer, AHB bridge, future peripherals).
- Decodes each request address against per-port base/mask windows. Forwards one transaction at a time and routes the response back.
- Added over the fixed 3-port router:
  - arbitrary port count;
  - optional default port;
  - decode-error response for unmapped addresses;
  - response timeout with drain of the stale transaction.

Parameters:
- PORT_NUM, 3, number of target ports (2..8).
- AWIDTH, 32, address width.
- DWIDTH, 32, data width.
- PORT_BASE, {0xF000_0000, 0xF004_0000, 0x0}, PORT_NUM×AWIDTH packed bases; port i occupies slice i.
- PORT_MASK, {0xFFFF_0000, 0xFFFF_FFE0, 0x0}, PORT_NUM×AWIDTH packed masks. A port matches when (addr & mask) == base.
- DFLT_EN, 1, when 1, unmatched addresses go to port PORT_NUM-1; when 0, they get an error response.
- TIMEOUT_CYC, 0, maximum response-wait cycles; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- core_req_ack_o  out  1  request accepted.
- core_req_i  in  1  request valid.
- core_cmd_i  in  type_scr1_mem_cmd_e  RD/WR.
- core_width_i  in  type_scr1_mem_width_e  BYTE/HWORD/WORD.
- core_addr_i  in  AWIDTH  address.
- core_wdata_i  in  DWIDTH  write data.
- core_rdata_o  out  DWIDTH  read data.
- core_resp_o  out  type_scr1_mem_resp_e  NOTRDY / RDY_OK / RDY_ER.
- port_req_ack_i  in  PORT_NUM  per-port accept.
- port_req_o  out  PORT_NUM  per-port request, one-hot or zero.
- port_cmd_o  out  type_scr1_mem_cmd_e  broadcast.
- port_width_o  out  type_scr1_mem_width_e  broadcast.
- port_addr_o  out  AWIDTH  broadcast.
- port_wdata_o  out  DWIDTH  broadcast.
- port_rdata_i  in  PORT_NUM×DWIDTH  per-port read data.
- port_resp_i  in  PORT_NUM×2  per-port response.

Behaviour:
- One clock domain, clk. Synchronous active-high rst. No outstanding-depth beyond 1.
- Decode (combinational):
  - The lowest-index matching port wins. Port PORT_NUM-1 is not decoded when DFLT_EN=1.
  - hit = any match, or DFLT_EN.
  - dec_sel = winning index, or PORT_NUM-1 on default.
- States: ADDR, DATA, DRAIN.
- Registers: state, sel (clog2 PORT_NUM), err_flag, tmo_cnt (clog2(TIMEOUT_CYC+1)).
- Request-issue condition. Requests are issued in either of two cases:
  - state==ADDR;
  - state==DATA and the current response is ready (resp≠NOTRDY or err_flag), giving back-to-back issue with zero bubble.
- When the issue condition holds:
  - On a hit: port_req_o[dec_sel] = core_req_i, and core_req_ack_o = port_req_ack_i[dec_sel].
  - On a miss: core_req_ack_o = core_req_i and no port_req. The handshake sets err_flag=1.
- Handshake (req & ack): sel<=dec_sel, err_flag<=miss, tmo_cnt<=0, state<=DATA.
- DATA:
  - core_resp_o: if err_flag, RDY_ER; else port_resp_i[sel].
  - core_rdata_o = port_rdata_i[sel] (0 when err_flag).
  - On response ready with no new handshake: go to ADDR.
  - On NOTRDY: tmo_cnt increments.
- Timeout:
  - Condition: TIMEOUT_CYC>0, tmo_cnt==TIMEOUT_CYC-1, and still NOTRDY.
  - core_resp_o=RDY_ER that cycle, and state<=DRAIN.
- DRAIN:
  - core_resp_o=NOTRDY, core_req_ack_o=0, all port_req_o=0.
  - Leave to ADDR when port_resp_i[sel]≠NOTRDY. That late response is discarded, never forwarded.
- In ADDR, core_resp_o=NOTRDY and core_rdata_o=0.
- Reset values: state=ADDR, sel=0, err_flag=0, tmo_cnt=0.
  - Outputs during and after reset: port_req_o=0, core_req_ack_o=0, core_resp_o=NOTRDY, core_rdata_o=0.
- Reset mid-transaction abandons it immediately. Targets are reset by the same reset.
- Broadcast cmd/width/addr/wdata pass through combinationally from core inputs.
- A port response arriving while the port is not selected is ignored.

Decomposition:
- Package scr1_router_pkg: state enum type_scr1_router_fsm_e {ADDR, DATA, DRAIN}, and function port_match(addr, base, mask).
- Memory types come from the existing memif header.
- One sub-module: scr1_router_addr_dec (priority decoder; outputs hit and dec_sel).

Test Plan:
- Read 0xF000_0010: port0 ack; resp RDY_OK with rdata 0x1234_5678 after 2 wait cycles → core gets 0x1234_5678 with RDY_OK on the third DATA cycle; only port_req_o[0] is ever set.
- Back-to-back: write to 0xF004_0004 followed immediately by a read of 0x2000_0000 (default port2) → second ack occurs in the same cycle as the port1 RDY_OK; no idle cycle.
- DFLT_EN=0, read 0x2000_0000 → ack in the same cycle; RDY_ER the next cycle; port_req_o stays 0.
- TIMEOUT_CYC=4, port2 stays NOTRDY → RDY_ER on the 4th DATA cycle. The next core request is held off until port2 responds 3 cycles later; that RDY_OK is not seen by the core.
- Overlap: base 0xF000_0000 in both port0 (mask 0xFFFF_0000) and port1 (mask 0xFFF0_0000) → port0 selected.
- rst asserted during DATA → next cycle state=ADDR, core_resp_o=NOTRDY, and a fresh request to port1 completes normally.
